// File: rtl/bus_sequencer.sv
`timescale 1ns/1ps
// Time-division sequencer: four fixed 16-clock slots (SPI, char, pixel, CPU) per 64-clock CPU cycle drive the shared bus.
// Latency: all outputs registered; SPI done 14 clocks after the phase-0 sample, CPU enable every 64 clocks at cnt 63.
// Backpressure: none; SPI master holds valid until done, an unsampled request simply waits for the next slot-0 phase 0.
module bus_sequencer #(
  parameter bit ROM_WRITE_PROTECT = 1'b1
) (
  input  logic        clk_sys_i,
  input  logic        reset_n_i,

  input  logic        spi_valid_i,
  input  logic [16:0] spi_addr_i,
  input  logic        spi_rw_n_i,
  output logic        spi_done_o,

  input  logic [15:0] cpu_addr_i,
  input  logic        cpu_rw_n_i,
  output logic        cpu_clk_en_o,

  input  logic [16:0] video_char_addr_i,
  input  logic [16:0] video_pixel_addr_i,
  output logic        video_char_load_o,
  output logic        video_pixel_load_o,

  input  logic        ram_en_i,
  input  logic        is_readonly_i,

  output logic [16:0] bus_addr_o,
  output logic        bus_rw_n_o,
  output logic        ram_oe_n_o,
  output logic        ram_we_n_o,
  output logic [1:0]  slot_o,
  output logic        bus_active_o
);

  typedef enum logic [1:0] {
    SLOT_SPI   = 2'd0,
    SLOT_CHAR  = 2'd1,
    SLOT_PIXEL = 2'd2,
    SLOT_CPU   = 2'd3
  } slot_e;

  // Strobe window inside a slot: one clock of address setup after phase 0/1
  // and one clock of hold before the phase-14 load pulse.
  localparam logic [3:0] STROBE_FIRST = 4'd2;
  localparam logic [3:0] STROBE_LAST  = 4'd13;
  localparam logic [3:0] LOAD_PHASE   = 4'd14;

  // Counter and its decoded next position. Every output is computed from the
  // next counter value so the registered outputs line up with cnt itself.
  logic [5:0]  cnt_q, cnt_d;
  logic [3:0]  phase_d;
  slot_e       slot_q, slot_d;

  // Bus ownership state, held for the whole slot.
  logic [16:0] bus_addr_q, bus_addr_d;
  logic        bus_rw_n_q, bus_rw_n_d;
  logic        active_q, active_d;

  // Strobes and pulses.
  logic        ram_oe_n_q, ram_oe_n_d;
  logic        ram_we_n_q, ram_we_n_d;
  logic        spi_done_q, spi_done_d;
  logic        char_load_q, char_load_d;
  logic        pixel_load_q, pixel_load_d;
  logic        cpu_clk_en_q, cpu_clk_en_d;

  logic        strobe_win;
  logic        load_win;
  logic        write_blocked;

  // Free-running 0..63 counter; slot and phase fall out of its bit fields.
  always_comb begin
    cnt_d   = cnt_q + 6'd1;
    phase_d = cnt_d[3:0];
    slot_d  = slot_e'(cnt_d[5:4]);
  end

  // Slot owner selection at phase 0; address and direction then hold for the slot.
  always_comb begin
    bus_addr_d = bus_addr_q;
    bus_rw_n_d = bus_rw_n_q;
    active_d   = active_q;
    if (phase_d == 4'd0) begin
      unique case (slot_d)
        SLOT_SPI: begin
          active_d = spi_valid_i;
          if (spi_valid_i) begin
            bus_addr_d = spi_addr_i;
            bus_rw_n_d = spi_rw_n_i;
          end else begin
            // Idle slot keeps the old address on the bus but never writes.
            bus_rw_n_d = 1'b1;
          end
        end
        SLOT_CHAR: begin
          active_d   = 1'b1;
          bus_addr_d = video_char_addr_i;
          bus_rw_n_d = 1'b1;
        end
        SLOT_PIXEL: begin
          active_d   = 1'b1;
          bus_addr_d = video_pixel_addr_i;
          bus_rw_n_d = 1'b1;
        end
        SLOT_CPU: begin
          active_d   = 1'b1;
          bus_addr_d = {1'b0, cpu_addr_i};
          bus_rw_n_d = cpu_rw_n_i;
        end
        default: begin
          active_d = 1'b0;
        end
      endcase
    end
  end

  // RAM strobes: decode results arrive combinationally from the bus address,
  // so they are sampled here one clock ahead of each strobe clock.
  always_comb begin
    strobe_win    = active_d && (phase_d >= STROBE_FIRST) && (phase_d <= STROBE_LAST);
    // Only the CPU is barred from read-only regions; SPI may load ROM images.
    write_blocked = (slot_d == SLOT_CPU) && ROM_WRITE_PROTECT && is_readonly_i;
    ram_oe_n_d    = !(strobe_win && bus_rw_n_d && ram_en_i);
    ram_we_n_d    = !(strobe_win && !bus_rw_n_d && ram_en_i && !write_blocked);
  end

  // Completion pulses for the slot owner and the CPU cycle enable.
  always_comb begin
    load_win     = active_d && (phase_d == LOAD_PHASE);
    spi_done_d   = load_win && (slot_d == SLOT_SPI);
    char_load_d  = load_win && (slot_d == SLOT_CHAR);
    pixel_load_d = load_win && (slot_d == SLOT_PIXEL);
    // The CPU advances once per 64 clocks regardless of what its slot decoded to.
    cpu_clk_en_d = (cnt_d == 6'd63);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_sys_i) begin
    if (!reset_n_i) begin
      cnt_q        <= 6'd0;
      slot_q       <= SLOT_SPI;
      bus_addr_q   <= 17'd0;
      bus_rw_n_q   <= 1'b1;
      active_q     <= 1'b0;
      ram_oe_n_q   <= 1'b1;
      ram_we_n_q   <= 1'b1;
      spi_done_q   <= 1'b0;
      char_load_q  <= 1'b0;
      pixel_load_q <= 1'b0;
      cpu_clk_en_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      slot_q       <= slot_d;
      bus_addr_q   <= bus_addr_d;
      bus_rw_n_q   <= bus_rw_n_d;
      active_q     <= active_d;
      ram_oe_n_q   <= ram_oe_n_d;
      ram_we_n_q   <= ram_we_n_d;
      spi_done_q   <= spi_done_d;
      char_load_q  <= char_load_d;
      pixel_load_q <= pixel_load_d;
      cpu_clk_en_q <= cpu_clk_en_d;
    end
  end

  assign bus_addr_o         = bus_addr_q;
  assign bus_rw_n_o         = bus_rw_n_q;
  assign ram_oe_n_o         = ram_oe_n_q;
  assign ram_we_n_o         = ram_we_n_q;
  assign slot_o             = slot_q;
  assign bus_active_o       = active_q;
  assign spi_done_o         = spi_done_q;
  assign video_char_load_o  = char_load_q;
  assign video_pixel_load_o = pixel_load_q;
  assign cpu_clk_en_o       = cpu_clk_en_q;

endmodule

// File: tb/tb_bus_sequencer.sv
`timescale 1ns/1ps
// Randomized bench for bus_sequencer with a slot-level reference model.
// Expected outputs are queued per clock by the stimulus side and popped by a monitor.
// Address decoding is modelled by a small combinational function driving the decode inputs.
module tb_bus_sequencer;

  localparam bit TB_WP = 1'b1;

  logic        clk;
  logic        reset_n;
  logic        spi_valid;
  logic [16:0] spi_addr;
  logic        spi_rw_n;
  logic        spi_done;
  logic [15:0] cpu_addr;
  logic        cpu_rw_n;
  logic        cpu_clk_en;
  logic [16:0] char_addr;
  logic [16:0] pix_addr;
  logic        char_load;
  logic        pix_load;
  logic        ram_en;
  logic        is_ro;
  logic [16:0] bus_addr;
  logic        bus_rw_n;
  logic        ram_oe_n;
  logic        ram_we_n;
  logic [1:0]  slot;
  logic        bus_active;

  bus_sequencer #(.ROM_WRITE_PROTECT(TB_WP)) dut (
    .clk_sys_i          (clk),
    .reset_n_i          (reset_n),
    .spi_valid_i        (spi_valid),
    .spi_addr_i         (spi_addr),
    .spi_rw_n_i         (spi_rw_n),
    .spi_done_o         (spi_done),
    .cpu_addr_i         (cpu_addr),
    .cpu_rw_n_i         (cpu_rw_n),
    .cpu_clk_en_o       (cpu_clk_en),
    .video_char_addr_i  (char_addr),
    .video_pixel_addr_i (pix_addr),
    .video_char_load_o  (char_load),
    .video_pixel_load_o (pix_load),
    .ram_en_i           (ram_en),
    .is_readonly_i      (is_ro),
    .bus_addr_o         (bus_addr),
    .bus_rw_n_o         (bus_rw_n),
    .ram_oe_n_o         (ram_oe_n),
    .ram_we_n_o         (ram_we_n),
    .slot_o             (slot),
    .bus_active_o       (bus_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment stand-in for address_decoding: IO window at E800-EFFF, ROM from 0A000 up.
  function automatic bit is_io(logic [16:0] a);
    return (a >= 17'h0E800) && (a <= 17'h0EFFF);
  endfunction
  function automatic bit dec_ram(logic [16:0] a);
    return !is_io(a);
  endfunction
  function automatic bit dec_ro(logic [16:0] a);
    return !is_io(a) && (a >= 17'h0A000);
  endfunction

  assign ram_en = dec_ram(bus_addr);
  assign is_ro  = dec_ro(bus_addr);

  typedef struct packed {
    logic [16:0] addr;
    logic        rw_n;
    logic        oe_n;
    logic        we_n;
    logic [1:0]  slot;
    logic        active;
    logic        spi_done;
    logic        char_load;
    logic        pix_load;
    logic        cpu_en;
  } obs_t;

  obs_t exp_q[$];
  obs_t mon_exp;
  obs_t mon_act;
  int   checks;
  int   errors;

  // Reference model state: position in the 64-clock frame and the current slot's access.
  int          m_cnt;
  bit          m_act;
  logic [16:0] m_addr;
  bit          m_rw;

  // Predict what the outputs show after the coming clock edge, from the inputs as driven now.
  task automatic predict();
    obs_t e;
    int   nc;
    int   sl;
    int   ph;
    e      = '0;
    e.rw_n = 1'b1;
    e.oe_n = 1'b1;
    e.we_n = 1'b1;
    if (!reset_n) begin
      m_cnt  = 0;
      m_act  = 1'b0;
      m_addr = '0;
      m_rw   = 1'b1;
    end else begin
      nc = (m_cnt + 1) % 64;
      sl = nc / 16;
      ph = nc % 16;
      if (ph == 0) begin
        if (sl == 0) begin
          m_act = spi_valid;
          if (spi_valid) begin
            m_addr = spi_addr;
            m_rw   = spi_rw_n;
          end else begin
            m_rw = 1'b1;
          end
        end else if (sl == 1) begin
          m_act = 1'b1; m_addr = char_addr; m_rw = 1'b1;
        end else if (sl == 2) begin
          m_act = 1'b1; m_addr = pix_addr; m_rw = 1'b1;
        end else begin
          m_act = 1'b1; m_addr = {1'b0, cpu_addr}; m_rw = cpu_rw_n;
        end
      end
      m_cnt    = nc;
      e.addr   = m_addr;
      e.rw_n   = m_rw;
      e.slot   = 2'(sl);
      e.active = m_act;
      if (m_act && ph >= 2 && ph <= 13 && dec_ram(m_addr)) begin
        if (m_rw) e.oe_n = 1'b0;
        else if (!(sl == 3 && TB_WP && dec_ro(m_addr))) e.we_n = 1'b0;
      end
      if (m_act && ph == 14) begin
        e.spi_done  = (sl == 0);
        e.char_load = (sl == 1);
        e.pix_load  = (sl == 2);
      end
      e.cpu_en = (nc == 63);
    end
    exp_q.push_back(e);
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        mon_act = '{addr: bus_addr, rw_n: bus_rw_n, oe_n: ram_oe_n, we_n: ram_we_n,
                    slot: slot, active: bus_active, spi_done: spi_done,
                    char_load: char_load, pix_load: pix_load, cpu_en: cpu_clk_en};
        checks++;
        if (mon_act !== mon_exp) begin
          errors++;
          if (errors <= 25)
            $display("FAIL outputs t=%0t got addr=%h rw=%b oe=%b we=%b slot=%0d act=%b done/cl/pl/cpu=%b%b%b%b required addr=%h rw=%b oe=%b we=%b slot=%0d act=%b done/cl/pl/cpu=%b%b%b%b",
                     $time, mon_act.addr, mon_act.rw_n, mon_act.oe_n, mon_act.we_n, mon_act.slot,
                     mon_act.active, mon_act.spi_done, mon_act.char_load, mon_act.pix_load, mon_act.cpu_en,
                     mon_exp.addr, mon_exp.rw_n, mon_exp.oe_n, mon_exp.we_n, mon_exp.slot,
                     mon_exp.active, mon_exp.spi_done, mon_exp.char_load, mon_exp.pix_load, mon_exp.cpu_en);
        end
      end
    end
  endtask

  // One clock: queue the expectation, let the edge happen, then play the SPI master.
  task automatic tick();
    predict();
    @(negedge clk);
    #1;
    if (spi_valid && spi_done) spi_valid = 1'b0;
  endtask

  task automatic set_round(input bit sv, input logic [16:0] sa, input bit srw,
                           input logic [15:0] ca, input bit crw,
                           input logic [16:0] va, input logic [16:0] pa);
    if (!spi_valid) begin
      spi_valid = sv;
      spi_addr  = sa;
      spi_rw_n  = srw;
    end
    cpu_addr  = ca;
    cpu_rw_n  = crw;
    char_addr = va;
    pix_addr  = pa;
  endtask

  function automatic logic [15:0] pick_cpu(input int k);
    logic [15:0] tbl [0:4];
    tbl = '{16'h0400, 16'hA000, 16'hE810, 16'h1234, 16'hFFFC};
    if (k > 4) return 16'($urandom_range(0, 16'hFFFF));
    return tbl[k];
  endfunction

  function automatic logic [16:0] pick_bus(input int k);
    logic [16:0] tbl [0:4];
    tbl = '{17'h00400, 17'h0A000, 17'h0E810, 17'h10000, 17'h08000};
    if (k > 4) return 17'($urandom_range(0, 17'h1FFFF));
    return tbl[k];
  endfunction

  int  lat;
  bit  found;
  int  guard;

  initial begin
    checks    = 0;
    errors    = 0;
    m_cnt     = 0;
    m_act     = 1'b0;
    m_addr    = '0;
    m_rw      = 1'b1;
    reset_n   = 1'b0;
    spi_valid = 1'b0;
    spi_addr  = '0;
    spi_rw_n  = 1'b1;
    cpu_addr  = '0;
    cpu_rw_n  = 1'b1;
    char_addr = '0;
    pix_addr  = '0;
    fork
      monitor();
    join_none
    @(negedge clk);
    #1;

    // Reset held for five clocks.
    repeat (5) tick();
    reset_n = 1'b1;

    // Move to cnt 16 so each directed block spans one full SPI sample and done.
    repeat (16) tick();
    set_round(1'b1, 17'h00400, 1'b1, 16'hE810, 1'b1, 17'h08000, 17'h10000);
    repeat (64) tick();
    set_round(1'b1, 17'h0A000, 1'b0, 16'hA000, 1'b0, 17'h08000, 17'h10000);
    repeat (64) tick();
    set_round(1'b0, 17'h00000, 1'b1, 16'h0400, 1'b0, 17'h0E810, 17'h10000);
    repeat (64) tick();

    // Reset at cnt 50 in the middle of a CPU write, SPI read held across it.
    set_round(1'b1, 17'h00400, 1'b1, 16'h0400, 1'b0, 17'h08000, 17'h10000);
    guard = 0;
    while (m_cnt != 50 && guard < 100) begin
      tick();
      guard++;
    end
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (100) tick();

    // Randomized traffic.
    repeat (1920) begin
      cpu_addr  = pick_cpu($urandom_range(0, 5));
      cpu_rw_n  = 1'($urandom_range(0, 1));
      char_addr = pick_bus($urandom_range(0, 5));
      pix_addr  = pick_bus($urandom_range(0, 5));
      if (!spi_valid && $urandom_range(0, 7) == 0) begin
        spi_valid = 1'b1;
        spi_addr  = pick_bus($urandom_range(0, 5));
        spi_rw_n  = 1'($urandom_range(0, 1));
      end
      tick();
    end

    // SPI latency for a request raised at cnt 5.
    guard = 0;
    while (spi_valid && guard < 200) begin
      tick();
      guard++;
    end
    guard = 0;
    while (m_cnt != 5 && guard < 100) begin
      tick();
      guard++;
    end
    spi_valid = 1'b1;
    spi_addr  = 17'h01234;
    spi_rw_n  = 1'b1;
    lat   = 0;
    found = 1'b0;
    while (!found && lat < 150) begin
      tick();
      lat++;
      if (spi_done) found = 1'b1;
    end
    checks++;
    if (!found || lat != 73) begin
      errors++;
      $display("FAIL spi_latency got %0d clocks (seen=%0b) required 73", lat, found);
    end
    repeat (20) tick();

    // Let the monitor consume the last expectation.
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
